// File: rtl/cpu6_membus_arb.sv
// cpu6_membus_arb: fixed-priority SRAM port arbiter (lsu > ifu > dma) with dma anti-starvation and pipelined read-data routing.
module cpu6_membus_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ifu_req,
  input  logic [XLEN-1:0] ifu_addr,
  output logic            ifu_gnt,
  output logic            ifu_rvalid,
  output logic [XLEN-1:0] ifu_rdata,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_gnt,
  output logic            lsu_rvalid,
  output logic [XLEN-1:0] lsu_rdata,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [XLEN-1:0] dma_addr,
  input  logic [XLEN-1:0] dma_wdata,
  output logic            dma_gnt,
  output logic            dma_rvalid,
  output logic [XLEN-1:0] dma_rdata,
  input  logic            mem_ready,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);
  typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU, OWN_DMA} owner_t;
  owner_t owner_q;
  logic we_q;
  logic [CNT_W-1:0] starve_cnt;
  logic starve_force, go;
  assign starve_force = starve_cnt >= CNT_W'(STARVE_MAX);
  // grants are masked by reset so an asserted reset silences the bus at once
  assign go = mem_ready & reset;
  assign dma_gnt = go & dma_req & (starve_force | (~lsu_req & ~ifu_req));
  assign lsu_gnt = go & lsu_req & ~dma_gnt;
  assign ifu_gnt = go & ifu_req & ~lsu_req & ~dma_gnt;
  assign mem_en = ifu_gnt | lsu_gnt | dma_gnt;
  assign mem_we = (lsu_gnt & lsu_we) | (dma_gnt & dma_we);
  assign mem_addr = ({XLEN{ifu_gnt}} & ifu_addr) | ({XLEN{lsu_gnt}} & lsu_addr) | ({XLEN{dma_gnt}} & dma_addr);
  assign mem_wdata = ({XLEN{lsu_gnt}} & lsu_wdata) | ({XLEN{dma_gnt}} & dma_wdata);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_NONE;
      we_q       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      owner_q    <= dma_gnt ? OWN_DMA : lsu_gnt ? OWN_LSU : ifu_gnt ? OWN_IFU : OWN_NONE;
      we_q       <= mem_we;
      starve_cnt <= (dma_gnt | ~dma_req) ? '0 :
                    (mem_ready && !starve_force) ? starve_cnt + 1'b1 : starve_cnt;
    end
  end
  assign ifu_rvalid = owner_q == OWN_IFU;
  assign lsu_rvalid = owner_q == OWN_LSU;
  assign dma_rvalid = owner_q == OWN_DMA;
  assign ifu_rdata = (ifu_rvalid && !we_q) ? mem_rdata : '0;
  assign lsu_rdata = (lsu_rvalid && !we_q) ? mem_rdata : '0;
  assign dma_rdata = (dma_rvalid && !we_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_cpu6_membus_arb.sv
// tb_cpu6_membus_arb: directed vectors with a due-cycle scoreboard for the returned responses.
module tb_cpu6_membus_arb;
  logic clk = 0;
  logic reset = 0;
  logic ifu_req = 0, lsu_req = 0, lsu_we = 0, dma_req = 0, dma_we = 0, mem_ready = 0;
  logic [31:0] ifu_addr = 0, lsu_addr = 0, lsu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [31:0] mem_rdata;
  logic ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
  logic [31:0] ifu_rdata, lsu_rdata, dma_rdata, mem_addr, mem_wdata;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {int due; int id; logic [31:0] data;} exp_t;
  exp_t q[$];

  cpu6_membus_arb #(.XLEN(32), .STARVE_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_ready(mem_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hC0DE0000);
  endfunction

  // SRAM stand-in: garbage on non-read cycles so stray rdata routing shows up
  always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? rd_val(mem_addr) : 32'hFFFFFFFF;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] rv;
    rv = {dma_rvalid, lsu_rvalid, ifu_rvalid};
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("rvalid", 32'(rv), 32'(3'b001 << (e.id - 1)));
      chk("ifu_rdata", ifu_rdata, e.id == 1 ? e.data : 32'h0);
      chk("lsu_rdata", lsu_rdata, e.id == 2 ? e.data : 32'h0);
      chk("dma_rdata", dma_rdata, e.id == 3 ? e.data : 32'h0);
    end else
      chk("rvalid_idle", 32'(rv), 32'h0);
  end

  // one bus cycle: eg = expected winner (0 none, 1 ifu, 2 lsu, 3 dma), ed = expected returned data
  task automatic step(input logic ir, lr, lw, dr, dw, rdy,
                      input logic [31:0] ia, la, lwd, da, dwd,
                      input int eg, input logic [31:0] ed);
    exp_t e;
    @(posedge clk);
    #1;
    {ifu_req, lsu_req, lsu_we, dma_req, dma_we, mem_ready} = {ir, lr, lw, dr, dw, rdy};
    {ifu_addr, lsu_addr, lsu_wdata, dma_addr, dma_wdata} = {ia, la, lwd, da, dwd};
    @(negedge clk);
    chk("gnt", 32'({dma_gnt, lsu_gnt, ifu_gnt}), eg == 0 ? 32'h0 : 32'(3'b001 << (eg - 1)));
    chk("mem_en", 32'(mem_en), 32'(eg != 0));
    chk("mem_we", 32'(mem_we), eg == 2 ? 32'(lw) : eg == 3 ? 32'(dw) : 32'h0);
    chk("mem_addr", mem_addr, eg == 1 ? ia : eg == 2 ? la : eg == 3 ? da : 32'h0);
    chk("mem_wdata", mem_wdata, eg == 2 ? lwd : eg == 3 ? dwd : 32'h0);
    if (eg != 0) begin
      e.due = cyc + 1; e.id = eg; e.data = ed;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_quiet(input string n);
    chk(n, 32'({ifu_gnt, lsu_gnt, dma_gnt, ifu_rvalid, lsu_rvalid, dma_rvalid, mem_en, mem_we}), 32'h0);
    chk(n, ifu_rdata | lsu_rdata | dma_rdata | mem_addr | mem_wdata, 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_quiet("reset_state");
    @(posedge clk);
    #1 reset = 1;
    // single ifu read
    step(1, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    idle();
    // lsu write beats ifu, ifu follows
    step(1, 1, 1, 0, 0, 1, 32'h104, 32'h200, 32'h55, 0, 0, 2, 32'h0);
    step(1, 0, 0, 0, 0, 1, 32'h104, 0, 0, 0, 0, 1, 32'hC0DE0104);
    idle();
    // dma starved by lsu: forced win on the 5th cycle, counter restarts
    repeat (4) step(0, 1, 0, 1, 0, 1, 0, 32'h300, 0, 32'h400, 0, 2, 32'hC0DE0300);
    step(0, 1, 0, 1, 0, 1, 0, 32'h300, 0, 32'h400, 0, 3, 32'hC0DE0400);
    step(0, 1, 0, 1, 0, 1, 0, 32'h300, 0, 32'h400, 0, 2, 32'hC0DE0300);
    idle();
    // mem_ready low for 3 cycles: counter holds, lsu wins on resume
    step(1, 1, 0, 1, 0, 1, 32'h700, 32'h300, 0, 32'h400, 0, 2, 32'hC0DE0300);
    repeat (3) step(1, 1, 0, 1, 0, 0, 32'h700, 32'h300, 0, 32'h400, 0, 0, 0);
    repeat (3) step(1, 1, 0, 1, 0, 1, 32'h700, 32'h300, 0, 32'h400, 0, 2, 32'hC0DE0300);
    step(1, 1, 0, 1, 0, 1, 32'h700, 32'h300, 0, 32'h400, 0, 3, 32'hC0DE0400);
    idle();
    // back-to-back ifu, lsu, ifu
    step(1, 0, 0, 0, 0, 1, 32'h108, 0, 0, 0, 0, 1, 32'hC0DE0108);
    step(1, 1, 0, 0, 0, 1, 32'h110, 32'h20C, 0, 0, 0, 2, 32'hC0DE020C);
    step(1, 0, 0, 0, 0, 1, 32'h110, 0, 0, 0, 0, 1, 32'hC0DE0110);
    // dma write completes with zero rdata
    step(0, 0, 0, 1, 1, 1, 0, 0, 0, 32'h500, 32'h77, 3, 32'h0);
    idle();
    // reset lands the cycle after an lsu read grant: its data is dropped
    step(0, 1, 0, 0, 0, 1, 0, 32'h600, 0, 0, 0, 2, 32'hC0DE0600);
    @(posedge clk);
    #1;
    reset = 0;
    q.delete();
    {ifu_req, lsu_req, dma_req} = 3'b111;
    #1 chk_quiet("reset_async");
    repeat (2) @(negedge clk);
    chk_quiet("reset_hold");
    {ifu_req, lsu_req, dma_req} = 3'b000;
    @(posedge clk);
    #1 reset = 1;
    step(1, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    idle();
    idle();
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
